sram8_bridge: RTL

Memory bridge between the rv32i core's 32-bit memory port and an external byte-wide synchronous SRAM. It turns every word read into four byte reads, and every masked store into byte writes for the selected lanes only. It stalls the core through `hold` until the access completes. A one-word read buffer with an address tag lets repeated reads of the same word (fetch, then load) complete without re-accessing the SRAM.

---
 rtl/sram8_pkg.sv | 27 ++
 rtl/sram8_bridge_beat_timer.sv | 34 +++
 rtl/sram8_bridge.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sram8_pkg.sv
// Shared types and helpers for the byte-wide SRAM bridge.
package sram8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_WR     = 2'd3
  } state_e;

  localparam int LANES     = 4;
  localparam int LANE_BITS = 2;

  // Lowest set lane at or above 'from'; MSB of the result flags that one exists.
  function automatic logic [LANE_BITS:0] next_set_lane(input logic [LANES-1:0] mask,
                                                       input logic [LANE_BITS:0] from);
    logic [LANE_BITS:0] res;
    res = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res = {1'b1, LANE_BITS'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram8_bridge_beat_timer.sv
// Wait-state down-counter shared by read and write beats.
module beat_timer #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(WAIT_STATES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram8_bridge.sv
// 32-bit core port to byte-wide synchronous SRAM, with a one-word tagged read buffer.
module sram8_bridge
  import sram8_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic [3:0]            cpu_write_mask,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_wdata,
  output logic                  sram_we,
  output logic                  sram_re,
  input  logic [7:0]            sram_rdata
);

  localparam int WW = ADDR_WIDTH - 2;

  state_e               state_q, state_d;
  logic [WW-1:0]        tag_q, tag_d;
  logic                 valid_q, valid_d;
  logic [31:0]          buf_q, buf_d;
  logic                 wr_done_q, wr_done_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;

  logic [WW-1:0]      word;
  logic               hit;
  logic               store_req;
  logic [LANE_BITS:0] first_lane;
  logic [LANE_BITS:0] after_lane;
  logic               timer_load;
  logic               timer_done;
  logic               unused_addr_bits;

  assign word             = cpu_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH], cpu_addr[1:0]};
  assign hit              = valid_q && (tag_q == word);
  assign store_req        = (cpu_write_mask != 4'b0000);
  assign first_lane       = next_set_lane(cpu_write_mask, '0);
  assign after_lane       = next_set_lane(cpu_write_mask, {1'b0, lane_q} + 3'd1);

  beat_timer #(
    .WAIT_STATES(WAIT_STATES)
  ) u_beat_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .done_o (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    buf_d      = buf_q;
    wr_done_d  = wr_done_q;
    lane_d     = lane_q;
    timer_load = 1'b0;
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = 8'h00;

    // A store is only repeated after the mask has dropped to zero.
    if (!store_req) begin
      wr_done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (store_req && !wr_done_q) begin
          state_d    = ST_WR;
          lane_d     = first_lane[LANE_BITS-1:0];
          timer_load = 1'b1;
        end else if (!store_req && !hit) begin
          state_d    = ST_RD_REQ;
          lane_d     = '0;
          timer_load = 1'b1;
        end
      end

      ST_RD_REQ: begin
        sram_re   = 1'b1;
        sram_addr = {word, lane_q};
        if (timer_done) begin
          state_d = ST_RD_CAP;
        end
      end

      ST_RD_CAP: begin
        buf_d[{lane_q, 3'b000} +: 8] = sram_rdata;
        if (lane_q == 2'd3) begin
          tag_d   = word;
          valid_d = 1'b1;
          lane_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lane_d     = lane_q + 2'd1;
          timer_load = 1'b1;
          state_d    = ST_RD_REQ;
        end
      end

      ST_WR: begin
        sram_we    = 1'b1;
        sram_addr  = {word, lane_q};
        sram_wdata = cpu_wdata[{lane_q, 3'b000} +: 8];
        if (timer_done) begin
          // Keep the read buffer coherent with stores to the buffered word.
          if (hit) begin
            buf_d[{lane_q, 3'b000} +: 8] = cpu_wdata[{lane_q, 3'b000} +: 8];
          end
          if (after_lane[LANE_BITS]) begin
            lane_d     = after_lane[LANE_BITS-1:0];
            timer_load = 1'b1;
          end else begin
            wr_done_d = 1'b1;
            lane_d    = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      buf_q     <= '0;
      wr_done_q <= 1'b0;
      lane_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      buf_q     <= buf_d;
      wr_done_q <= wr_done_d;
      lane_q    <= lane_d;
    end
  end

  assign cpu_rdata = buf_q;
  assign cpu_hold  = store_req ? !wr_done_q : ((state_q != ST_IDLE) || !hit);

endmodule
